tlb_refill_walker: RTL

Hardware TLB refill engine for the 8-entry fully-associative TLB. On a TLB miss it walks a two-level page table in physical memory and writes the resulting 24-bit PTE into the TLB by random replacement (drives tlbwr/pte_in/vpn). An invalid entry or a memory timeout raises a one-cycle page fault to CP0 instead. It sits between the MMU lookup path, CP0 (page-table base) and the memory arbiter.

---
 rtl/tlb_refill_walker_pkg.sv | 43 ++++
 rtl/tlb_refill_walker_if.sv | 53 +++++
 rtl/tlb_refill_walker_walk_timeout_ctr.sv | 48 ++++
 rtl/tlb_refill_walker.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/tlb_refill_walker_pkg.sv
// -----------------------------------------------------------------------------
// tlb_refill_walker_pkg
// Shared definitions for the TLB refill walker: walk FSM states, fault-cause
// codes, bit positions inside a PDE/PTE entry and the entry-address helper.
// Optional feature macro: TLB_WALK_ACCESSED_EN (adds the ST_ACCW state usage).
// -----------------------------------------------------------------------------
package tlb_refill_walker_pkg;

    localparam int VPN_W = 20;
    localparam int PFN_W = 20;
    localparam int PTE_W = 24;

    // Entry layout shared by PDE and PTE
    localparam int PTE_V       = 0;
    localparam int PTE_A       = 1;
    localparam int PTE_C       = 2;
    localparam int PTE_D       = 3;
    localparam int PTE_PFN_LSB = 4;
    localparam int PTE_PFN_MSB = 23;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PDE   = 3'd1,
        ST_PTE   = 3'd2,
        ST_WRITE = 3'd3,
        ST_FAULT = 3'd4,
        ST_ACCW  = 3'd5
    } walk_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_PDE_INV = 2'b01,
        CAUSE_PTE_INV = 2'b10,
        CAUSE_TIMEOUT = 2'b11
    } fault_cause_e;

    // Both table levels hold 1024 word-sized entries per 4 KiB frame
    function automatic logic [31:0] entry_addr(input logic [PFN_W-1:0] frame,
                                               input logic [9:0]       index);
        return {frame, index, 2'b00};
    endfunction

endpackage

// File: rtl/tlb_refill_walker_if.sv
// -----------------------------------------------------------------------------
// tlb_refill_walker_if
// Bundles the walker's MMU miss request, CP0 page-table base, memory read
// port, TLB write port and fault report into one interface.
//   master : the walker (drives busy, mem_req/mem_addr, tlbwr/tlb_*, fault_*)
//   slave  : the surrounding system (drives miss_*, ptbase, mem_ack/mem_rdata)
// With TLB_WALK_ACCESSED_EN defined the memory port also carries
// mem_we/mem_wdata for the accessed-bit write-back.
// -----------------------------------------------------------------------------
interface tlb_refill_walker_if;
    import tlb_refill_walker_pkg::*;

    logic             miss_req;
    logic [VPN_W-1:0] miss_vpn;
    logic [PFN_W-1:0] ptbase;
    logic             busy;

    logic             mem_req;
    logic [31:0]      mem_addr;
    logic             mem_ack;
    logic [31:0]      mem_rdata;
`ifdef TLB_WALK_ACCESSED_EN
    logic             mem_we;
    logic [31:0]      mem_wdata;
`endif

    logic             tlbwr;
    logic [PTE_W-1:0] tlb_pte;
    logic [VPN_W-1:0] tlb_vpn;

    logic             page_fault;
    logic [1:0]       fault_cause;
    logic [VPN_W-1:0] fault_vpn;

    modport master (
        input  miss_req, miss_vpn, ptbase, mem_ack, mem_rdata,
        output busy, mem_req, mem_addr, tlbwr, tlb_pte, tlb_vpn,
               page_fault, fault_cause, fault_vpn
`ifdef TLB_WALK_ACCESSED_EN
        , output mem_we, mem_wdata
`endif
    );

    modport slave (
        output miss_req, miss_vpn, ptbase, mem_ack, mem_rdata,
        input  busy, mem_req, mem_addr, tlbwr, tlb_pte, tlb_vpn,
               page_fault, fault_cause, fault_vpn
`ifdef TLB_WALK_ACCESSED_EN
        , input mem_we, mem_wdata
`endif
    );

endinterface

// File: rtl/tlb_refill_walker_walk_timeout_ctr.sv
// -----------------------------------------------------------------------------
// walk_timeout_ctr
// Down-counting wait counter for one memory access of the walker.
//   clk, clrn : clock, asynchronous active-low reset
//   clr_i     : force the counter to zero (walker not waiting on memory)
//   load_i    : reload LIMIT (entry into a memory-access state)
//   en_i      : one wait cycle elapsed (request outstanding, no ack)
//   tc_o      : this wait cycle is the LIMIT-th one
// A LIMIT of zero loads zero, which never reaches the terminal value, so the
// timeout is disabled.
// -----------------------------------------------------------------------------
module walk_timeout_ctr #(
    parameter logic [7:0] LIMIT = 8'd255
) (
    input  logic clk,
    input  logic clrn,
    input  logic clr_i,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    logic [7:0] cnt_q, cnt_d;

    // Next count: clear wins over reload, reload wins over decrement
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (load_i) begin
            cnt_d = LIMIT;
        end else if (en_i && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Independent of load_i so the walker can use it to pick its next state
    assign tc_o = en_i && (cnt_q == 8'd1);

endmodule

// File: rtl/tlb_refill_walker.sv
// -----------------------------------------------------------------------------
// tlb_refill_walker
// Hardware refill engine for the 8-entry fully-associative TLB. On a miss it
// reads the PDE and then the PTE of a two-level page table, and either writes
// the PTE into the TLB (random replacement) or reports a page fault to CP0.
//   clk, clrn : clock, asynchronous active-low reset
//   bus       : tlb_refill_walker_if.master (miss request, ptbase, memory read
//               port, TLB write strobe, fault strobe and held fault info)
// Parameter TIMEOUT_CYC : wait cycles allowed per memory access, 0 = no limit.
// Optional macro TLB_WALK_ACCESSED_EN : write the accessed bit back to a PTE
// that has it clear before installing it (adds mem_we/mem_wdata).
// Every output is decoded from registered state only.
// -----------------------------------------------------------------------------
module tlb_refill_walker
    import tlb_refill_walker_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 clrn,
    tlb_refill_walker_if.master  bus
);

    walk_state_e      state_q, state_d;
    logic [VPN_W-1:0] vpn_q, vpn_d;
    logic [PFN_W-1:0] base_q, base_d;
    logic [PFN_W-1:0] pfn_q, pfn_d;
    logic [PTE_W-1:0] pte_q, pte_d;
    logic [1:0]       cause_q, cause_d;
    logic [VPN_W-1:0] fvpn_q, fvpn_d;

    logic in_req;
    logic next_in_req;
    logic wait_tc;
    logic unused_rdata_hi;

    assign in_req      = state_q inside {ST_PDE, ST_PTE, ST_ACCW};
    assign next_in_req = state_d inside {ST_PDE, ST_PTE, ST_ACCW};
    assign unused_rdata_hi = ^bus.mem_rdata[31:24];

    walk_timeout_ctr #(
        .LIMIT (TIMEOUT_CYC[7:0])
    ) u_timeout (
        .clk    (clk),
        .clrn   (clrn),
        .clr_i  (!next_in_req),
        .load_i (next_in_req && (state_d != state_q)),
        .en_i   (in_req && !bus.mem_ack),
        .tc_o   (wait_tc)
    );

    // Walk sequencing and capture of the PDE/PTE fields
    always_comb begin
        state_d = state_q;
        vpn_d   = vpn_q;
        base_d  = base_q;
        pfn_d   = pfn_q;
        pte_d   = pte_q;
        cause_d = cause_q;
        fvpn_d  = fvpn_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.miss_req) begin
                    vpn_d   = bus.miss_vpn;
                    base_d  = bus.ptbase;
                    state_d = ST_PDE;
                end
            end
            ST_PDE: begin
                if (bus.mem_ack) begin
                    if (bus.mem_rdata[PTE_V]) begin
                        pfn_d   = bus.mem_rdata[PTE_PFN_MSB:PTE_PFN_LSB];
                        state_d = ST_PTE;
                    end else begin
                        cause_d = CAUSE_PDE_INV;
                        state_d = ST_FAULT;
                    end
                end else if (wait_tc) begin
                    cause_d = CAUSE_TIMEOUT;
                    state_d = ST_FAULT;
                end
            end
            ST_PTE: begin
                if (bus.mem_ack) begin
                    if (bus.mem_rdata[PTE_V]) begin
`ifdef TLB_WALK_ACCESSED_EN
                        // pte_q holds the entry with A already set; it is both
                        // the write-back data and the value given to the TLB
                        pte_d   = bus.mem_rdata[PTE_W-1:0] | (24'd1 << PTE_A);
                        state_d = bus.mem_rdata[PTE_A] ? ST_WRITE : ST_ACCW;
`else
                        pte_d   = bus.mem_rdata[PTE_W-1:0];
                        state_d = ST_WRITE;
`endif
                    end else begin
                        cause_d = CAUSE_PTE_INV;
                        state_d = ST_FAULT;
                    end
                end else if (wait_tc) begin
                    cause_d = CAUSE_TIMEOUT;
                    state_d = ST_FAULT;
                end
            end
`ifdef TLB_WALK_ACCESSED_EN
            ST_ACCW: begin
                if (bus.mem_ack) begin
                    state_d = ST_WRITE;
                end else if (wait_tc) begin
                    cause_d = CAUSE_TIMEOUT;
                    state_d = ST_FAULT;
                end
            end
`endif
            ST_WRITE: state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (state_d == ST_FAULT) begin
            fvpn_d = vpn_q;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= ST_IDLE;
            vpn_q   <= '0;
            base_q  <= '0;
            pfn_q   <= '0;
            pte_q   <= '0;
            cause_q <= CAUSE_NONE;
            fvpn_q  <= '0;
        end else begin
            state_q <= state_d;
            vpn_q   <= vpn_d;
            base_q  <= base_d;
            pfn_q   <= pfn_d;
            pte_q   <= pte_d;
            cause_q <= cause_d;
            fvpn_q  <= fvpn_d;
        end
    end

    // Memory address: the directory is indexed by vpn[19:10], the page table
    // by vpn[9:0]; the PTE write-back reuses the PTE address
    always_comb begin
        bus.mem_addr = 32'd0;
        case (state_q)
            ST_PDE:          bus.mem_addr = entry_addr(base_q, vpn_q[19:10]);
            ST_PTE, ST_ACCW: bus.mem_addr = entry_addr(pfn_q, vpn_q[9:0]);
            default:         bus.mem_addr = 32'd0;
        endcase
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.mem_req     = in_req;
    assign bus.tlbwr       = (state_q == ST_WRITE);
    assign bus.tlb_pte     = (state_q == ST_WRITE) ? pte_q : '0;
    assign bus.tlb_vpn     = (state_q == ST_WRITE) ? vpn_q : '0;
    assign bus.page_fault  = (state_q == ST_FAULT);
    assign bus.fault_cause = cause_q;
    assign bus.fault_vpn   = fvpn_q;

`ifdef TLB_WALK_ACCESSED_EN
    assign bus.mem_we    = (state_q == ST_ACCW);
    assign bus.mem_wdata = (state_q == ST_ACCW) ? {8'h00, pte_q} : 32'd0;
`endif

endmodule
